// File: rtl/vga_interface.sv
// VGA 640x480@60 timing generator with pixel colour pass-through; outputs decode the counters combinationally (zero latency).
// No backpressure: the counters free-run at one pixel per clock, and the colour source must keep pace with ColunaOut/LinhaOut.
module vga_interface #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [23:0] RGB,
  output logic        h_sync,
  output logic        v_sync,
  output logic        blank,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic [9:0]  ColunaOut,
  output logic [9:0]  LinhaOut
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS       = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS       = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  // Reset parks both counters on the last pixel of the frame so that the
  // first free-running edge lands on (0,0) and blank rises one clock later.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (Reset) begin
      h_d = H_LAST;
      v_d = V_LAST;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end else begin
      h_d = h_q + 10'd1;
    end
  end

  always_ff @(posedge Clock) begin
    h_q <= h_d;
    v_q <= v_d;
  end

  always_comb begin
    blank     = (h_q < H_VIS) && (v_q < V_VIS);
    h_sync    = !((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END));
    v_sync    = !((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END));
    R         = blank ? RGB[23:16] : 8'h00;
    G         = blank ? RGB[15:8]  : 8'h00;
    B         = blank ? RGB[7:0]   : 8'h00;
    ColunaOut = h_q;
    LinhaOut  = v_q;
  end

endmodule

// File: tb/tb_vga_interface.sv
// Directed bench: full-size timing instance plus a shrunken-geometry instance for whole-frame checks.
module tb_vga_interface;

  logic        Clock;
  logic        Reset;
  logic [23:0] RGB;

  logic       hs0, vs0, bl0;
  logic [7:0] r0, g0, b0;
  logic [9:0] col0, lin0;

  logic       hs1, vs1, bl1;
  logic [7:0] r1, g1, b1;
  logic [9:0] col1, lin1;

  int n_cmp = 0;
  int n_err = 0;

  vga_interface u_full (
    .Clock(Clock), .Reset(Reset), .RGB(RGB),
    .h_sync(hs0), .v_sync(vs0), .blank(bl0),
    .R(r0), .G(g0), .B(b0),
    .ColunaOut(col0), .LinhaOut(lin0)
  );

  // 15 clocks per line (8 visible, sync at 10..12), 13 lines per frame (6 visible, sync on lines 8..9)
  vga_interface #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_small (
    .Clock(Clock), .Reset(Reset), .RGB(RGB),
    .h_sync(hs1), .v_sync(vs1), .blank(bl1),
    .R(r1), .G(g1), .B(b1),
    .ColunaOut(col1), .LinhaOut(lin1)
  );

  initial Clock = 1'b0;
  always #20 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge Clock);
      @(negedge Clock);
    end
  endtask

  initial begin
    int bl_hi, hs_lo, hs_first, vs_lo, vs_first_line, rises, sm_bl_hi;
    logic prev_bl;

    Reset = 1'b1;
    RGB   = 24'hFF8001;
    tick(2);
    check("rst_blank",  bl0,  1'b0);
    check("rst_hsync",  hs0,  1'b1);
    check("rst_vsync",  vs0,  1'b1);
    check("rst_rgb",    {r0, g0, b0}, 24'h000000);
    check("rst_col",    col0, 10'd799);
    check("rst_lin",    lin0, 10'd524);
    check("rst_small_col", col1, 10'd14);
    check("rst_small_lin", lin1, 10'd12);

    Reset = 1'b0;
    tick(1);
    check("rel_blank", bl0,  1'b1);
    check("rel_col",   col0, 10'd0);
    check("rel_lin",   lin0, 10'd0);
    check("rel_rgb",   {r0, g0, b0}, 24'hFF8001);

    // One full line starting at h=0, v=0
    bl_hi = 0; hs_lo = 0; hs_first = -1;
    for (int i = 0; i < 800; i++) begin
      if (bl0) bl_hi++;
      if (!hs0) begin
        hs_lo++;
        if (hs_first < 0) hs_first = i;
      end
      if (i == 639) check("rgb_last_visible", {r0, g0, b0}, 24'hFF8001);
      if (i == 640) check("rgb_first_blank",  {r0, g0, b0}, 24'h000000);
      if (i == 655) check("hsync_before", hs0, 1'b1);
      if (i == 751) check("hsync_last",   hs0, 1'b0);
      if (i == 752) check("hsync_after",  hs0, 1'b1);
      tick(1);
    end
    check("line_blank_hi", bl_hi,    32'd640);
    check("line_hsync_lo", hs_lo,    32'd96);
    check("line_hsync_at", hs_first, 32'd656);
    check("line_period_col", col0, 10'd0);
    check("line_period_lin", lin0, 10'd1);

    // Advance from (0,1) to (799,10), then across the line wrap
    tick(9 * 800 + 799);
    check("pre_wrap_col",   col0, 10'd799);
    check("pre_wrap_lin",   lin0, 10'd10);
    check("pre_wrap_blank", bl0,  1'b0);
    check("pre_wrap_vsync", vs0,  1'b1);
    tick(1);
    check("wrap_col",   col0, 10'd0);
    check("wrap_lin",   lin0, 10'd11);
    check("wrap_blank", bl0,  1'b1);

    // Mid-frame reset for a single clock
    RGB = 24'h123456;
    tick(300);
    check("mid_col",   col0, 10'd300);
    check("mid_lin",   lin0, 10'd11);
    check("mid_rgb",   {r0, g0, b0}, 24'h123456);
    Reset = 1'b1;
    tick(1);
    check("mid_rst_col",   col0, 10'd799);
    check("mid_rst_lin",   lin0, 10'd524);
    check("mid_rst_blank", bl0,  1'b0);
    check("mid_rst_rgb",   {r0, g0, b0}, 24'h000000);
    Reset = 1'b0;
    tick(1);
    check("mid_rel_col", col0, 10'd0);
    check("mid_rel_lin", lin0, 10'd0);
    check("mid_rel_blank", bl0, 1'b1);

    // One whole frame of the small instance, which also restarted at (0,0)
    vs_lo = 0; vs_first_line = -1; rises = 0; sm_bl_hi = 0; prev_bl = 1'b0;
    for (int i = 0; i < 15 * 13; i++) begin
      if (!vs1) begin
        vs_lo++;
        if (vs_first_line < 0) vs_first_line = int'(lin1);
      end
      if (bl1 && !prev_bl) rises++;
      if (bl1) sm_bl_hi++;
      if (!bl1 && ({r1, g1, b1} !== 24'h000000)) check("small_rgb_blank", {r1, g1, b1}, 24'h000000);
      prev_bl = bl1;
      tick(1);
    end
    check("frame_vsync_lo",   vs_lo,         32'd30);
    check("frame_vsync_line", vs_first_line, 32'd8);
    check("frame_blank_rise", rises,         32'd6);
    check("frame_blank_hi",   sm_bl_hi,      32'd48);
    check("frame_period_col", col1, 10'd0);
    check("frame_period_lin", lin1, 10'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_interface.md
VGA_INTERFACE -- requirements
Module: vga_interface

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-005 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 Clock  input  1  pixel clock (25 MHz), the only clock; all state updates on its rising edge.
REQ-010 Reset  input  1  synchronous, active-high reset.
REQ-011 RGB  input  24  pixel colour from the graphics block; [23:16]=red, [15:8]=green, [7:0]=blue.
REQ-012 h_sync  output  1  horizontal sync, active low.
REQ-013 v_sync  output  1  vertical sync, active low.
REQ-014 blank  output  1  active-high display-enable (drives VGA_BLANK_N); 1 only in the visible area.
REQ-015 R, G, B  output  8 each  colour to the DAC.
REQ-016 ColunaOut  output  10  current horizontal counter (column).
REQ-017 LinhaOut  output  10  current vertical counter (line).

Function
REQ-018 Horizontal counter h SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800), wrapping to 0.
REQ-019 Vertical counter v SHALL increment only when h wraps from H_TOTAL-1 to 0; range 0..V_TOTAL-1 (525), wrapping to 0 at the same edge as h.
REQ-020 ColunaOut SHALL equal h and LinhaOut SHALL equal v, driven directly from the counter registers.
REQ-021 blank SHALL be 1 iff h < H_VISIBLE and v < V_VISIBLE, decoded from the counter registers in the same cycle.
REQ-022 h_sync SHALL be 0 iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (656..751), else 1.
REQ-023 v_sync SHALL be 0 iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (490..491), else 1.
REQ-024 R/G/B SHALL be the combinational pass-through of RGB fields while blank=1 and 8'h00 while blank=0; zero pipeline latency, so the colour for (ColunaOut, LinhaOut) appears in the same cycle.
REQ-025 Visible pixel (x,y) SHALL be presented during the cycle where h=x, v=y; a downstream sampler on the falling clock edge following the rising edge of blank captures column 0 first.

Reset
REQ-026 While Reset=1 at a rising edge: h <= H_TOTAL-1 (799), v <= V_TOTAL-1 (524).
REQ-027 Resulting outputs during reset: blank=0, h_sync=1, v_sync=1, R=G=B=0, ColunaOut=799, LinhaOut=524.
REQ-028 First rising edge with Reset=0 SHALL move to h=0, v=0, so blank rises exactly one clock after reset release, starting frame line 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame at the next edge; no partial state is retained.

Verification
REQ-030 Reset 2 clocks, release -> blank 0 during reset, 1 on first post-release edge with ColunaOut=0, LinhaOut=0.
REQ-031 RGB=24'hFF8001 constant -> during visible area R=FF, G=80, B=01; outside visible area R=G=B=00.
REQ-032 Count one line -> blank high 640 clocks, low 160; h_sync low exactly 96 clocks starting at h=656; period 800.
REQ-033 Count one frame -> v_sync low for lines 490..491 (1600 clocks), frame period 420000 clocks, blank rising edges 480 per frame.
REQ-034 Wrap check -> at h=799,v=524 next edge gives h=0,v=0; at h=799,v=10 next edge gives h=0,v=11.
REQ-035 Assert Reset at h=300,v=200 for 1 clock -> counters 799/524, then 0/0 one clock after release.
